// File: rtl/interrupt_controller.sv
// Eight-source prioritised interrupt controller: synchronises and latches IRQ lines,
// issues one request at a time to the core's sequencer and tracks in-service nesting.
module interrupt_controller #(
  parameter int         NUM_IRQ       = 8,
  parameter logic [9:0] VECTOR_TOP    = 10'd1009,
  parameter int         VECTOR_STRIDE = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irqIn,
  input  logic               regWrite,
  input  logic               regRead,
  input  logic [1:0]         regAddr,
  input  logic [7:0]         regWriteData,
  output logic [7:0]         regReadData,
  output logic               intReq,
  output logic [2:0]         intId,
  output logic [9:0]         isrAddress,
  input  logic               intAck,
  input  logic               intEoi
);

  localparam logic [9:0] STRIDE = 10'(VECTOR_STRIDE);

  // Returns {found, index} of the highest set bit.
  function automatic logic [3:0] hi_bit(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = {1'b1, 3'(i)};
      else      r = r;
    end
    return r;
  endfunction

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, syncd_q;
  logic [7:0] mask_q, mask_d, pend_q, pend_d, edge_q, edge_d, insvc_q, insvc_d;
  logic [7:0] rdata_q, rdata_d;
  logic       req_q, req_d;
  logic [2:0] id_q, id_d;

  logic [7:0] rise_s, set_s, w1c_s, ack_bit_s, eoi_bit_s, active_s, rd_mux_s;
  logic [3:0] cand_s, top_s;

  // Next-state logic for registers, request and read data.
  always_comb begin
    rise_s    = sync2_q & ~syncd_q;
    set_s     = (edge_q & rise_s) | (~edge_q & sync2_q);
    mask_d    = mask_q;
    edge_d    = edge_q;
    w1c_s     = 8'd0;
    if (regWrite) begin
      case (regAddr)
        2'd0:    mask_d = regWriteData;
        2'd1:    w1c_s  = regWriteData;
        2'd2:    edge_d = regWriteData;
        default: w1c_s  = 8'd0;
      endcase
    end else begin
      w1c_s = 8'd0;
    end

    ack_bit_s = (intAck && req_q) ? (8'd1 << id_q) : 8'd0;
    top_s     = hi_bit(insvc_q);
    eoi_bit_s = (intEoi && top_s[3]) ? (8'd1 << top_s[2:0]) : 8'd0;
    // Set wins over ack/W1C clear, so a held level source re-latches immediately.
    pend_d    = (pend_q & ~(ack_bit_s | w1c_s)) | set_s;
    insvc_d   = (insvc_q & ~eoi_bit_s) | ack_bit_s;

    active_s  = pend_q & mask_q;
    cand_s    = hi_bit(active_s);
    req_d     = cand_s[3] && (!top_s[3] || (cand_s[2:0] > top_s[2:0]));
    id_d      = cand_s[3] ? cand_s[2:0] : id_q;

    case (regAddr)
      2'd0:    rd_mux_s = mask_q;
      2'd1:    rd_mux_s = pend_q;
      2'd2:    rd_mux_s = edge_q;
      default: rd_mux_s = insvc_q;
    endcase
    rdata_d = regRead ? rd_mux_s : rdata_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      syncd_q <= '0;
      mask_q  <= 8'h00;
      pend_q  <= 8'h00;
      edge_q  <= 8'hFF;
      insvc_q <= 8'h00;
      rdata_q <= 8'h00;
      req_q   <= 1'b0;
      id_q    <= 3'd0;
    end else begin
      sync1_q <= irqIn;
      sync2_q <= sync1_q;
      syncd_q <= sync2_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      edge_q  <= edge_d;
      insvc_q <= insvc_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      id_q    <= id_d;
    end
  end

  assign regReadData = rdata_q;
  assign intReq      = req_q;
  assign intId       = id_q;
  assign isrAddress  = VECTOR_TOP - (STRIDE * {7'd0, id_q});

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; expected values go through a scoreboard queue.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst, regWrite, regRead, intAck, intEoi;
  logic [7:0] irqIn, regWriteData, regReadData;
  logic [1:0] regAddr;
  logic       intReq;
  logic [2:0] intId;
  logic [9:0] isrAddress;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .irqIn(irqIn), .regWrite(regWrite), .regRead(regRead),
    .regAddr(regAddr), .regWriteData(regWriteData), .regReadData(regReadData),
    .intReq(intReq), .intId(intId), .isrAddress(isrAddress),
    .intAck(intAck), .intEoi(intEoi)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [15:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    push(tag, exp);
    compare(obs);
  endtask

  task automatic check_req(input string tag, input logic exp_req, input logic [2:0] exp_id,
                           input logic [9:0] exp_addr);
    check({tag, "_req"}, {15'd0, intReq}, {15'd0, exp_req});
    if (exp_req) begin
      check({tag, "_id"}, {13'd0, intId}, {13'd0, exp_id});
      check({tag, "_addr"}, {6'd0, isrAddress}, {6'd0, exp_addr});
    end else begin
      check({tag, "_noreq"}, {15'd0, intReq}, 16'd0);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    regWrite = 1'b1; regAddr = a; regWriteData = d;
    tick();
    regWrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    push(tag, {8'd0, exp});
    regRead = 1'b1; regAddr = a;
    tick();
    regRead = 1'b0;
    compare({8'd0, regReadData});
  endtask

  task automatic ack();
    intAck = 1'b1; tick(); intAck = 1'b0;
  endtask

  task automatic eoi();
    intEoi = 1'b1; tick(); intEoi = 1'b0;
  endtask

  task automatic irq_pulse(input logic [7:0] v, input int n);
    irqIn = v; tick(n); irqIn = 8'h00;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, {15'd0, intReq}, 16'd0);
    check({tag, "_id"}, {13'd0, intId}, 16'd0);
    check({tag, "_addr"}, {6'd0, isrAddress}, 16'd1009);
    check({tag, "_rdata"}, {8'd0, regReadData}, 16'd0);
    rd({tag, "_mask"}, 2'd0, 8'h00);
    rd({tag, "_pend"}, 2'd1, 8'h00);
    rd({tag, "_edge"}, 2'd2, 8'hFF);
    rd({tag, "_insvc"}, 2'd3, 8'h00);
  endtask

  initial begin
    rst = 1'b1; irqIn = 8'h00; regWrite = 1'b0; regRead = 1'b0; regAddr = 2'd0;
    regWriteData = 8'h00; intAck = 1'b0; intEoi = 1'b0;
    tick(2);
    rst = 1'b0;
    check_reset("rst");

    // Basic request: four-edge latency, then ack and EOI.
    wr(2'd0, 8'h04);
    irqIn = 8'h04; tick(3);
    irqIn = 8'h00;
    check_req("basic_early", 1'b0, 3'd0, 10'd0);
    tick();
    check_req("basic", 1'b1, 3'd2, 10'd1003);
    ack();
    rd("basic_pend", 2'd1, 8'h00);
    check_req("basic_after_ack", 1'b0, 3'd0, 10'd0);
    rd("basic_insvc", 2'd3, 8'h04);
    eoi();
    rd("basic_eoi", 2'd3, 8'h00);

    // Nesting: 1 in service, 5 preempts, 3 waits for EOI of 5.
    wr(2'd0, 8'hFF);
    irq_pulse(8'h02, 4);
    check_req("nest_src1", 1'b1, 3'd1, 10'd1006);
    ack();
    tick();
    irq_pulse(8'h20, 4);
    check_req("nest_src5", 1'b1, 3'd5, 10'd994);
    ack();
    rd("nest_insvc22", 2'd3, 8'h22);
    irq_pulse(8'h08, 4);
    tick();
    check_req("nest_src3_blocked", 1'b0, 3'd0, 10'd0);
    eoi();
    check_req("nest_eoi_lag", 1'b0, 3'd0, 10'd0);
    tick();
    check_req("nest_src3", 1'b1, 3'd3, 10'd1000);
    rd("nest_insvc02", 2'd3, 8'h02);
    ack();
    tick();
    eoi();
    eoi();
    rd("nest_clean", 2'd3, 8'h00);

    // Masked source still latches; W1C clears it.
    wr(2'd0, 8'h00);
    irq_pulse(8'h80, 4);
    check_req("mask_noreq", 1'b0, 3'd0, 10'd0);
    rd("mask_pend", 2'd1, 8'h80);
    wr(2'd1, 8'h80);
    rd("w1c_pend", 2'd1, 8'h00);

    // Same-cycle read and write of one address returns the old value.
    regWrite = 1'b1; regWriteData = 8'h3C; regAddr = 2'd0;
    push("rw_same", 16'h0000);
    regRead = 1'b1;
    tick();
    regRead = 1'b0; regWrite = 1'b0;
    compare({8'd0, regReadData});
    rd("rw_after", 2'd0, 8'h3C);
    wr(2'd3, 8'hFF);
    rd("insvc_ro", 2'd3, 8'h00);

    // Level mode: held line re-latches after ack and wins over W1C.
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h01);
    irqIn = 8'h01;
    tick(4);
    check_req("lvl", 1'b1, 3'd0, 10'd1009);
    ack();
    rd("lvl_pend_ack", 2'd1, 8'h01);
    check_req("lvl_no_self", 1'b0, 3'd0, 10'd0);
    wr(2'd1, 8'h01);
    rd("lvl_pend_w1c", 2'd1, 8'h01);
    irqIn = 8'h00;
    tick(3);
    wr(2'd1, 8'h01);
    rd("lvl_pend_clr", 2'd1, 8'h00);
    eoi();
    wr(2'd2, 8'hFF);
    rd("lvl_insvc", 2'd3, 8'h00);

    // Same-cycle ack(6)+EOI with source 7 in service.
    wr(2'd0, 8'hC0);
    irq_pulse(8'hC0, 4);
    check_req("sim_src7", 1'b1, 3'd7, 10'd988);
    wr(2'd1, 8'h80);
    check_req("sim_stale7", 1'b1, 3'd7, 10'd988);
    ack();
    check_req("sim_src6", 1'b1, 3'd6, 10'd991);
    intAck = 1'b1; intEoi = 1'b1;
    tick();
    intAck = 1'b0; intEoi = 1'b0;
    rd("sim_insvc", 2'd3, 8'h40);
    rd("sim_pend", 2'd1, 8'h00);

    // Spurious ack while no request is raised.
    irq_pulse(8'h40, 4);
    check_req("spur_noreq", 1'b0, 3'd0, 10'd0);
    ack();
    rd("spur_pend", 2'd1, 8'h40);
    rd("spur_insvc", 2'd3, 8'h40);

    // Reset mid-service.
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset("rst_mid");
    tick(5);
    check_req("rst_mid_quiet", 1'b0, 3'd0, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
